// File: rtl/sha_block_reader.sv
// sha_block_reader: fetches one SHA message block of WORDS 32-bit words from a
// BRAM-style read interface and presents it as one wide vector.
// Ports:
//   axi_clk, axi_rst         clock, asynchronous active-high reset
//   start, base_addr         fetch request and byte address of word 0
//   busy                     high while fetching (REQ/WAIT)
//   sha_start_read           one-cycle read strobe per word
//   sha_bram_addr            byte address of the word being read
//   sha_bram_read_data       read data, valid when bram_complete is high
//   bram_complete            read transaction finished
//   msg_block                assembled block, word 0 in the top 32 bits
//   block_valid, block_ack   block handshake with the consumer
//   timeout_err              sticky flag: a word read did not complete in time
module sha_block_reader #(
  parameter int unsigned WORDS     = 16,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  output logic                  busy,
  output logic                  sha_start_read,
  output logic [31:0]           sha_bram_addr,
  input  logic [31:0]           sha_bram_read_data,
  input  logic                  bram_complete,
  output logic [32*WORDS-1:0]   msg_block,
  output logic                  block_valid,
  input  logic                  block_ack,
  output logic                  timeout_err
);

  localparam int unsigned BW = 32 * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state, state_n;
  logic [IW-1:0]  idx, idx_n;
  logic [CW-1:0]  wait_cnt, wait_cnt_n;
  logic [31:0]    addr_n;
  logic           wr_en;
  logic           busy_n;
  logic           start_read_n;
  logic           block_valid_n;
  logic           timeout_err_n;
  logic [31:0]    word_q [WORDS];

  // Next-state, next-output and word-store decode
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    wait_cnt_n    = wait_cnt;
    addr_n        = sha_bram_addr;
    wr_en         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_REQ;
          idx_n   = '0;
          addr_n  = base_addr;
        end
      end
      S_REQ: begin
        state_n    = S_WAIT;
        wait_cnt_n = '0;
      end
      S_WAIT: begin
        if (bram_complete) begin
          wr_en = 1'b1;
          if (idx == IW'(WORDS - 1)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_REQ;
            idx_n   = idx + IW'(1);
            // Address advances incrementally; 32-bit arithmetic wraps naturally
            addr_n  = sha_bram_addr + 32'(ADDR_STEP);
          end
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          state_n = S_ERR;
        end else begin
          wait_cnt_n = wait_cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (block_ack) state_n = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          state_n = S_REQ;
          idx_n   = '0;
          addr_n  = base_addr;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it
    busy_n        = (state_n == S_REQ) || (state_n == S_WAIT);
    start_read_n  = (state_n == S_REQ);
    block_valid_n = (state_n == S_DONE);
    timeout_err_n = (state_n == S_ERR);
  end

  // State and output registers
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      wait_cnt       <= '0;
      sha_bram_addr  <= '0;
      busy           <= 1'b0;
      sha_start_read <= 1'b0;
      block_valid    <= 1'b0;
      timeout_err    <= 1'b0;
      for (int i = 0; i < int'(WORDS); i++) word_q[i] <= '0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      wait_cnt       <= wait_cnt_n;
      sha_bram_addr  <= addr_n;
      busy           <= busy_n;
      sha_start_read <= start_read_n;
      block_valid    <= block_valid_n;
      timeout_err    <= timeout_err_n;
      if (wr_en) word_q[idx] <= sha_bram_read_data;
    end
  end

  // Word 0 occupies the most-significant 32 bits
  for (genvar i = 0; i < int'(WORDS); i++) begin : g_pack
    assign msg_block[BW-1-32*i -: 32] = word_q[i];
  end

endmodule

// File: tb/tb_sha_block_reader.sv
module tb_sha_block_reader;

  localparam int unsigned WORDS     = 16;
  localparam int unsigned ADDR_STEP = 4;
  localparam int unsigned TIMEOUT   = 255;
  localparam int unsigned BW        = 32 * WORDS;

  logic          axi_clk = 1'b0;
  logic          axi_rst;
  logic          start;
  logic [31:0]   base_addr;
  logic          busy;
  logic          sha_start_read;
  logic [31:0]   sha_bram_addr;
  logic [31:0]   sha_bram_read_data;
  logic          bram_complete;
  logic [BW-1:0] msg_block;
  logic          block_valid;
  logic          block_ack;
  logic          timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];

  sha_block_reader #(
    .WORDS(WORDS), .ADDR_STEP(ADDR_STEP), .TIMEOUT(TIMEOUT)
  ) dut (
    .axi_clk            (axi_clk),
    .axi_rst            (axi_rst),
    .start              (start),
    .base_addr          (base_addr),
    .busy               (busy),
    .sha_start_read     (sha_start_read),
    .sha_bram_addr      (sha_bram_addr),
    .sha_bram_read_data (sha_bram_read_data),
    .bram_complete      (bram_complete),
    .msg_block          (msg_block),
    .block_valid        (block_valid),
    .block_ack          (block_ack),
    .timeout_err        (timeout_err)
  );

  always #5 axi_clk = ~axi_clk;
  always @(posedge axi_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int k);
    return 32'(msg_block >> (32 * (int'(WORDS) - 1 - k)));
  endfunction

  task automatic push_expect(input logic [31:0] base, input logic [31:0] seed, input int n);
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(base + 32'(k * int'(ADDR_STEP)));
      exp_data.push_back(seed + 32'(k));
    end
  endtask

  // Bounded wait for the read strobe of word k, then compare its address
  task automatic wait_req(input int k, output logic [31:0] ea);
    int n = 0;
    while (!sha_start_read && n < 50) begin
      @(negedge axi_clk);
      n++;
    end
    ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : 32'hxxxx_xxxx;
    check($sformatf("req%0d", k), 64'(sha_start_read), 64'(1));
    check($sformatf("addr%0d", k), 64'(sha_bram_addr), 64'(ea));
  endtask

  // BRAM model: completes lat cycles after the request; poke adds ignored start/ack
  task automatic serve_word(input int k, input int lat, input logic [31:0] data, input bit poke);
    logic [31:0] ea;
    wait_req(k, ea);
    check($sformatf("bv_low%0d", k), 64'(block_valid), 64'(0));
    repeat (lat) begin
      @(negedge axi_clk);
      check($sformatf("busy_wait%0d", k), 64'(busy), 64'(1));
      check($sformatf("addr_hold%0d", k), 64'(sha_bram_addr), 64'(ea));
      check($sformatf("srd_low%0d", k), 64'(sha_start_read), 64'(0));
    end
    bram_complete      = 1'b1;
    sha_bram_read_data = data;
    if (poke) begin
      start     = 1'b1;
      base_addr = 32'hDEAD_0000;
      block_ack = 1'b1;
    end
    @(negedge axi_clk);
    bram_complete      = 1'b0;
    sha_bram_read_data = 32'h0;
    start              = 1'b0;
    block_ack          = 1'b0;
  endtask

  task automatic check_block();
    for (int k = 0; k < int'(WORDS); k++) begin
      logic [31:0] ed;
      ed = (exp_data.size() > 0) ? exp_data.pop_front() : 32'hxxxx_xxxx;
      check($sformatf("word%0d", k), 64'(word_of(k)), 64'(ed));
    end
  endtask

  task automatic run_fetch(input logic [31:0] base, input int lat, input logic [31:0] seed,
                           input int poke_word, input int exp_cycles);
    int c0;
    push_expect(base, seed, int'(WORDS));
    c0        = cyc;
    start     = 1'b1;
    base_addr = base;
    @(negedge axi_clk);
    start = 1'b0;
    check("busy_start", 64'(busy), 64'(1));
    check("te_cleared", 64'(timeout_err), 64'(0));
    for (int k = 0; k < int'(WORDS); k++) serve_word(k, lat, seed + 32'(k), k == poke_word);
    check("bv_done", 64'(block_valid), 64'(1));
    check("busy_done", 64'(busy), 64'(0));
    check("latency", 64'(cyc - c0), 64'(exp_cycles));
    check_block();
  endtask

  // Ack in DONE coinciding with start: start must be ignored
  task automatic ack_with_start();
    block_ack = 1'b1;
    start     = 1'b1;
    base_addr = 32'h5555_0000;
    @(negedge axi_clk);
    block_ack = 1'b0;
    start     = 1'b0;
    check("bv_after_ack", 64'(block_valid), 64'(0));
    check("busy_after_ack", 64'(busy), 64'(0));
    check("srd_after_ack", 64'(sha_start_read), 64'(0));
    @(negedge axi_clk);
    check("idle_stays", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [31:0] ea;
    int nw;
    axi_rst            = 1'b1;
    start              = 1'b0;
    base_addr          = 32'h0;
    sha_bram_read_data = 32'h0;
    bram_complete      = 1'b0;
    block_ack          = 1'b0;
    repeat (3) @(negedge axi_clk);

    check("rst_busy", 64'(busy), 64'(0));
    check("rst_srd", 64'(sha_start_read), 64'(0));
    check("rst_bv", 64'(block_valid), 64'(0));
    check("rst_te", 64'(timeout_err), 64'(0));
    check("rst_addr", 64'(sha_bram_addr), 64'(0));
    check("rst_block", 64'(msg_block == '0), 64'(1));

    // Basic fetch; start coincides with the first cycle out of reset
    axi_rst = 1'b0;
    run_fetch(32'h0000_0040, 1, 32'hA000_0000, -1, 2 * int'(WORDS) + 1);
    check("blk_top", 64'(msg_block[BW-1 -: 32]), 64'(32'hA000_0000));
    check("blk_bot", 64'(msg_block[31:0]), 64'(32'hA000_000F));
    // Late completion in DONE must not disturb the frozen block
    bram_complete = 1'b1;
    sha_bram_read_data = 32'hBAD0_BAD0;
    @(negedge axi_clk);
    bram_complete = 1'b0;
    check("done_frozen", 64'(word_of(0)), 64'(32'hA000_0000));
    check("done_bv", 64'(block_valid), 64'(1));
    ack_with_start();

    // Three-cycle completion latency
    run_fetch(32'h0000_0040, 3, 32'hA000_0000, -1, int'(WORDS) * 4 + 1);
    ack_with_start();

    // Address wrap past 2^32
    run_fetch(32'hFFFF_FFF8, 1, 32'h5000_0000, -1, 2 * int'(WORDS) + 1);
    ack_with_start();

    // Completion withheld on word 5
    push_expect(32'h0000_0100, 32'h7000_0000, 6);
    start     = 1'b1;
    base_addr = 32'h0000_0100;
    @(negedge axi_clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) serve_word(k, 1, 32'h7000_0000 + 32'(k), 1'b0);
    wait_req(5, ea);
    nw = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge axi_clk);
      if (busy && !timeout_err) nw++;
      else break;
    end
    check("timeout_cycles", 64'(nw), 64'(TIMEOUT));
    check("te_set", 64'(timeout_err), 64'(1));
    check("err_busy", 64'(busy), 64'(0));
    check("err_srd", 64'(sha_start_read), 64'(0));
    for (int k = 0; k < 5; k++) begin
      ea = exp_data.pop_front();
      check($sformatf("kept%0d", k), 64'(word_of(k)), 64'(ea));
    end
    check("kept5_old", 64'(word_of(5)), 64'(32'h5000_0005));
    exp_data.delete();
    @(negedge axi_clk);
    check("te_sticky", 64'(timeout_err), 64'(1));
    run_fetch(32'h0000_0200, 2, 32'h3000_0000, -1, int'(WORDS) * 3 + 1);
    ack_with_start();

    // Start and ack poked mid-fetch are ignored
    run_fetch(32'h0000_0300, 1, 32'h1111_0000, 3, 2 * int'(WORDS) + 1);
    ack_with_start();
    // Completion in IDLE is ignored
    bram_complete = 1'b1;
    sha_bram_read_data = 32'hFFFF_FFFF;
    @(negedge axi_clk);
    bram_complete = 1'b0;
    check("idle_cmpl_ign", 64'(word_of(0)), 64'(32'h1111_0000));
    check("idle_cmpl_busy", 64'(busy), 64'(0));

    // Reset asserted during the word 7 WAIT
    push_expect(32'h0000_0400, 32'h9000_0000, 8);
    start     = 1'b1;
    base_addr = 32'h0000_0400;
    @(negedge axi_clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) serve_word(k, 1, 32'h9000_0000 + 32'(k), 1'b0);
    wait_req(7, ea);
    @(negedge axi_clk);
    check("w7_wait", 64'(busy), 64'(1));
    #1 axi_rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_srd", 64'(sha_start_read), 64'(0));
    check("mid_rst_addr", 64'(sha_bram_addr), 64'(0));
    check("mid_rst_bv", 64'(block_valid), 64'(0));
    check("mid_rst_te", 64'(timeout_err), 64'(0));
    check("mid_rst_block", 64'(msg_block == '0), 64'(1));
    exp_addr.delete();
    exp_data.delete();
    @(negedge axi_clk);
    axi_rst = 1'b0;
    run_fetch(32'h0000_0400, 1, 32'h6000_0000, -1, 2 * int'(WORDS) + 1);
    ack_with_start();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/sha_block_reader.md
SHA_BLOCK_READER -- requirements
Module: sha_block_reader

Interface
REQ-001 Parameter WORDS, default 16: 32-bit words fetched per message block.
REQ-002 Parameter ADDR_STEP, default 4: byte increment between consecutive word addresses.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles per word before error.
REQ-004 axi_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 axi_rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to fetch a block.
REQ-007 base_addr  input  32  byte address of word 0, sampled with start.
REQ-008 busy  output  1  high in REQ and WAIT states.
REQ-009 sha_start_read  output  1  one-cycle read request to the BRAM interface.
REQ-010 sha_bram_addr  output  32  word byte address to the BRAM interface.
REQ-011 sha_bram_read_data  input  32  read data from the BRAM interface.
REQ-012 bram_complete  input  1  BRAM transaction done; read data valid this cycle.
REQ-013 msg_block  output  32*WORDS  assembled block, word 0 in most-significant 32 bits.
REQ-014 block_valid  output  1  msg_block complete and stable.
REQ-015 block_ack  input  1  consumer has taken msg_block.
REQ-016 timeout_err  output  1  sticky fetch-timeout flag.

Function
REQ-017 States IDLE, REQ, WAIT, DONE, ERR; all outputs registered.
REQ-018 IDLE: start=1 latches base_addr, clears word index and timeout_err, moves to REQ.
REQ-019 REQ: sha_start_read=1 for exactly this cycle; sha_bram_addr = base + index*ADDR_STEP, modulo 2^32; then WAIT.
REQ-020 sha_bram_addr stays stable from REQ through the end of WAIT for the same word.
REQ-021 bram_complete is sampled only in WAIT; assertion in any other state is ignored.
REQ-022 WAIT with bram_complete=1: sha_bram_read_data stored into word[index], i.e. msg_block bits [32*(WORDS-index)-1 -: 32].
REQ-023 After store: index==WORDS-1 goes to DONE, otherwise index increments and goes to REQ.
REQ-024 WAIT counter clears on WAIT entry and increments each WAIT cycle without bram_complete; reaching TIMEOUT goes to ERR.
REQ-025 Zero-wait latency: start sampled at edge 0, block_valid high after edge 2*WORDS+1 (33 cycles at WORDS=16).
REQ-026 DONE: block_valid=1 and msg_block frozen; block_ack=1 goes to IDLE, with block_valid low from the next cycle.
REQ-027 start is ignored in REQ, WAIT and DONE, including when it coincides with block_ack.
REQ-028 ERR: timeout_err=1 and busy=0, with partial msg_block contents retained.
REQ-029 ERR with start=1 clears timeout_err, latches the new base_addr and goes to REQ.
REQ-030 block_ack outside DONE has no effect.

Reset
REQ-031 axi_rst=1 forces IDLE asynchronously, in any state including mid-fetch.
REQ-032 During reset, busy, sha_start_read, block_valid and timeout_err are 0.
REQ-033 During reset, sha_bram_addr, msg_block, index and WAIT counter are all 0.
REQ-034 The first start after reset release is honoured in the first cycle axi_rst=0.

Verification
REQ-035 Reset, start with base_addr=0x0000_0040, BRAM model completes 1 cycle after each request returning 0xA000_0000+index -> addresses 0x40,0x44,…,0x7C; msg_block[511:480]=0xA0000000, [31:0]=0xA000000F; block_valid after 33 cycles.
REQ-036 Same as REQ-035 with 3-cycle completion latency -> identical data; block_valid after 16*4+1=65 cycles; busy high throughout.
REQ-037 base_addr=0xFFFF_FFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, … wrap correctly.
REQ-038 bram_complete withheld on word 5 -> ERR after 255 WAIT cycles, timeout_err=1 and words 0-4 retained; next start clears the flag and refetches.
REQ-039 start pulsed mid-fetch and in DONE simultaneously with block_ack -> both ignored, with IDLE reached and block_valid=0 the cycle after the ack.
REQ-040 axi_rst asserted during word 7 WAIT -> all outputs 0 immediately; a new start then produces a full correct block.
